// File: rtl/cache_bus_pkg.sv
// Shared encodings for the cache-side bridge arbiter: read/write FSM states,
// the line read type and the requester identifiers.
package cache_bus_pkg;

    // Read FSM, one-hot
    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_REQ  = 3'b010,
        R_RESP = 3'b100
    } rd_state_e;

    // Write-back FSM
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_WAIT = 2'd2
    } wr_state_e;

    // Requester identifiers, also used as bit positions in req/gnt vectors
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

endpackage

// File: rtl/arb_grant2.sv
// Two-way grant between I (bit REQ_I) and D (bit REQ_D).
// Build option ARB_RR_EN: round-robin on ties using a registered rr_last;
// otherwise fixed D > I priority with no state at all.
module arb_grant2
    import cache_bus_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef ARB_RR_EN
    req_id_e rr_last;

    // Tie goes to the requester that did not win last time
    always_comb begin
        gnt = '0;
        if (req[REQ_I] && req[REQ_D]) begin
            if (rr_last == REQ_I) gnt[REQ_D] = 1'b1;
            else                  gnt[REQ_I] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    // Remember the winner of every grant actually taken
    always_ff @(posedge clk) begin
        if (rst)
            rr_last <= REQ_I;
        else if (en && (|req))
            rr_last <= gnt[REQ_D] ? REQ_D : REQ_I;
    end
`else
    // Fixed priority: D wins whenever it asks
    always_comb begin
        gnt = '0;
        if (req[REQ_D])      gnt[REQ_D] = 1'b1;
        else if (req[REQ_I]) gnt[REQ_I] = 1'b1;
    end
`endif

endmodule

// File: rtl/cache_bridge_arbiter.sv
// Shares the single bridge port between I-cache and D-cache.
// One outstanding read burst at a time, beats routed to the owner; D-cache
// write-backs forwarded independently, and any read to a line with a
// write in flight is held until the bridge reports wr_done.
// Build option ARB_RR_EN selects round-robin instead of D > I priority.
module cache_bridge_arbiter
    import cache_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned OFF_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_req,
    input  logic [2:0]        i_rd_type,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    input  logic              d_rd_req,
    input  logic [2:0]        d_rd_type,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    input  logic              d_wr_req,
    input  logic [2:0]        d_wr_type,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [3:0]        d_wr_wstrb,
    input  logic [LINE_W-1:0] d_wr_data,
    output logic              d_wr_rdy,
    output logic              rd_req,
    output logic [2:0]        rd_type,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    output logic              wr_req,
    output logic [2:0]        wr_type,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_wstrb,
    output logic [LINE_W-1:0] wr_data,
    input  logic              wr_rdy,
    input  logic              wr_done
);

    localparam int unsigned LA_W = ADDR_W - OFF_W;

    rd_state_e         r_state, r_next;
    wr_state_e         w_state, w_next;
    req_id_e           owner;
    logic [ADDR_W-1:0] lat_addr;
    logic [2:0]        lat_type;
    logic [1:0]        beat_cnt;
    logic [LA_W-1:0]   wr_line;
    logic [LA_W-1:0]   pend_line;
    logic              pend_valid;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic              take_grant;

    // Pending write line: still on d_wr_addr while offered, latched once accepted
    always_comb begin
        pend_valid = (w_state == W_REQ) || (w_state == W_WAIT);
        pend_line  = (w_state == W_REQ) ? d_wr_addr[ADDR_W-1:OFF_W] : wr_line;
        elig        = '0;
        elig[REQ_I] = i_rd_req && !(pend_valid && (i_rd_addr[ADDR_W-1:OFF_W] == pend_line));
        elig[REQ_D] = d_rd_req && !(pend_valid && (d_rd_addr[ADDR_W-1:OFF_W] == pend_line));
        take_grant  = (r_state == R_IDLE) && (|elig);
    end

    arb_grant2 u_grant (
`ifdef ARB_RR_EN
        .clk (clk),
        .rst (rst),
        .en  (r_state == R_IDLE),
`endif
        .req (elig),
        .gnt (gnt)
    );

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Capture owner and request attributes at grant
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= REQ_D;
            lat_addr <= '0;
            lat_type <= '0;
        end else if (take_grant) begin
            owner    <= gnt[REQ_D] ? REQ_D : REQ_I;
            lat_addr <= gnt[REQ_I] ? i_rd_addr : d_rd_addr;
            lat_type <= gnt[REQ_I] ? i_rd_type : d_rd_type;
        end
    end

    // Return-beat counter; a line burst never exceeds four beats
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (r_state == R_RESP && ret_valid) begin
            assert (!(beat_cnt == 2'd3 && !ret_last));
            beat_cnt <= ret_last ? 2'd0 : beat_cnt + 2'd1;
        end
    end

    // Read FSM next state and read-side outputs
    always_comb begin
        r_next      = r_state;
        rd_req      = 1'b0;
        rd_type     = '0;
        rd_addr     = '0;
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (|elig) r_next = R_REQ;
            end
            R_REQ: begin
                rd_req  = 1'b1;
                rd_type = lat_type;
                rd_addr = lat_addr;
                if (owner == REQ_D) d_rd_rdy = rd_rdy;
                else                i_rd_rdy = rd_rdy;
                if (rd_rdy) r_next = R_RESP;
            end
            R_RESP: begin
                if (owner == REQ_D) begin
                    d_ret_valid = ret_valid;
                    d_ret_last  = ret_last;
                end else begin
                    i_ret_valid = ret_valid;
                    i_ret_last  = ret_last;
                end
                if (ret_valid && ret_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Latch the accepted write's line address for hazard checks in W_WAIT
    always_ff @(posedge clk) begin
        if (rst)
            wr_line <= '0;
        else if (w_state == W_REQ && wr_rdy)
            wr_line <= d_wr_addr[ADDR_W-1:OFF_W];
    end

    // Write FSM next state and write-side outputs
    always_comb begin
        w_next   = w_state;
        wr_req   = 1'b0;
        wr_type  = '0;
        wr_addr  = '0;
        wr_wstrb = '0;
        wr_data  = '0;
        d_wr_rdy = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (d_wr_req) w_next = W_REQ;
            end
            W_REQ: begin
                wr_req   = d_wr_req;
                wr_type  = d_wr_type;
                wr_addr  = d_wr_addr;
                wr_wstrb = d_wr_wstrb;
                wr_data  = d_wr_data;
                d_wr_rdy = wr_rdy;
                if (wr_rdy) w_next = W_WAIT;
            end
            W_WAIT: begin
                if (wr_done) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_bridge_arbiter.sv
// Bench for cache_bridge_arbiter: a transaction-level model compared against
// the DUT every cycle, plus literal expectations for each directed scenario.
// Define ARB_RR_EN for both bench and RTL to exercise round-robin grants.
module tb_cache_bridge_arbiter;
    import cache_bus_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int OFF_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_rd_req = 1'b0, d_rd_req = 1'b0, d_wr_req = 1'b0;
    logic [2:0]        i_rd_type = '0, d_rd_type = '0, d_wr_type = '0;
    logic [ADDR_W-1:0] i_rd_addr = '0, d_rd_addr = '0, d_wr_addr = '0;
    logic [3:0]        d_wr_wstrb = '0;
    logic [LINE_W-1:0] d_wr_data = '0;
    logic              rd_rdy = 1'b0, ret_valid = 1'b0, ret_last = 1'b0;
    logic              wr_rdy = 1'b0, wr_done = 1'b0;
    logic              i_rd_rdy, i_ret_valid, i_ret_last;
    logic              d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy;
    logic              rd_req, wr_req;
    logic [2:0]        rd_type, wr_type;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [3:0]        wr_wstrb;
    logic [LINE_W-1:0] wr_data;

    cache_bridge_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst(rst),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
        .wr_wstrb(wr_wstrb), .wr_data(wr_data),
        .wr_rdy(wr_rdy), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit                m_busy = 0;      // a read burst is owned
    bit                m_acc  = 0;      // bridge has accepted it, beats flowing
    bit                m_own_d = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [2:0]        m_type = '0;
    int                m_wph = 0;       // 0 none, 1 offered, 2 awaiting done
    logic [ADDR_W-OFF_W-1:0] m_wline = '0;
`ifdef ARB_RR_EN
    bit                m_rr_d = 0;      // last grant went to D
`endif

    bit                e_rd_req, e_in_resp, e_wr_off, m_pend, m_ei, m_ed, m_win_d;
    logic [ADDR_W-OFF_W-1:0] m_pline;
    logic [ADDR_W-1:0] e_rd_addr;
    logic [2:0]        e_rd_type;

    // observations for literal checks
    int                n_i_beats = 0, n_d_beats = 0, n_i_last = 0, n_d_last = 0;
    int                last_d_cyc = -1;
    int                grant_cyc[$];
    logic [ADDR_W-1:0] grant_addr[$];
    bit                prev_rd_req = 0;

    always @(negedge clk) begin
        e_rd_req  = m_busy && !m_acc;
        e_in_resp = m_busy && m_acc;
        e_rd_addr = e_rd_req ? m_addr : '0;
        e_rd_type = e_rd_req ? m_type : '0;
        e_wr_off  = (m_wph == 1);
        check("rd_chan", {rd_req, rd_type, rd_addr}, {e_rd_req, e_rd_type, e_rd_addr});
        check("i_side", {i_rd_rdy, i_ret_valid, i_ret_last},
              {e_rd_req && !m_own_d && rd_rdy, e_in_resp && !m_own_d && ret_valid,
               e_in_resp && !m_own_d && ret_last});
        check("d_side", {d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy},
              {e_rd_req && m_own_d && rd_rdy, e_in_resp && m_own_d && ret_valid,
               e_in_resp && m_own_d && ret_last, e_wr_off && wr_rdy});
        check("wr_chan", {wr_req, wr_type, wr_addr, wr_wstrb},
              {e_wr_off && d_wr_req, e_wr_off ? d_wr_type : 3'd0,
               e_wr_off ? d_wr_addr : 32'd0, e_wr_off ? d_wr_wstrb : 4'd0});
        check("wr_data", wr_data, e_wr_off ? d_wr_data : 128'd0);

        // advance the model across the coming edge
        if (rst) begin
            m_busy = 0; m_acc = 0; m_wph = 0;
`ifdef ARB_RR_EN
            m_rr_d = 0;
`endif
        end else begin
            if (!m_busy) begin
                m_pend  = (m_wph != 0);
                m_pline = (m_wph == 1) ? d_wr_addr[ADDR_W-1:OFF_W] : m_wline;
                m_ei = i_rd_req && !(m_pend && i_rd_addr[ADDR_W-1:OFF_W] == m_pline);
                m_ed = d_rd_req && !(m_pend && d_rd_addr[ADDR_W-1:OFF_W] == m_pline);
                if (m_ei || m_ed) begin
`ifdef ARB_RR_EN
                    m_win_d = (m_ei && m_ed) ? !m_rr_d : m_ed;
                    m_rr_d  = m_win_d;
`else
                    m_win_d = m_ed;
`endif
                    m_busy  = 1; m_acc = 0; m_own_d = m_win_d;
                    m_addr  = m_win_d ? d_rd_addr : i_rd_addr;
                    m_type  = m_win_d ? d_rd_type : i_rd_type;
                end
            end else if (!m_acc) begin
                if (rd_rdy) m_acc = 1;
            end else if (ret_valid && ret_last) begin
                m_busy = 0;
            end
            if (m_wph == 0 && d_wr_req) m_wph = 1;
            else if (m_wph == 1 && wr_rdy) begin
                m_wph = 2; m_wline = d_wr_addr[ADDR_W-1:OFF_W];
            end else if (m_wph == 2 && wr_done) m_wph = 0;
        end

        // raw observations
        if (i_ret_valid) n_i_beats++;
        if (d_ret_valid) n_d_beats++;
        if (i_ret_valid && i_ret_last) n_i_last++;
        if (d_ret_valid && d_ret_last) begin n_d_last++; last_d_cyc = cyc; end
        if (rd_req && !prev_rd_req) begin
            grant_cyc.push_back(cyc);
            grant_addr.push_back(rd_addr);
        end
        prev_rd_req = rd_req;
    end

    function automatic logic [ADDR_W-1:0] g_addr(input int k);
        if (k < grant_addr.size()) return grant_addr[k];
        return 'x;
    endfunction

    function automatic int g_cyc(input int k);
        if (k < grant_cyc.size()) return grant_cyc[k];
        return -1000;
    endfunction

    task automatic clear_obs();
        n_i_beats = 0; n_d_beats = 0; n_i_last = 0; n_d_last = 0;
        last_d_cyc = -1;
        grant_cyc.delete();
        grant_addr.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_rd_req(output bit ok);
        ok = 0;
        for (int k = 0; k < 80; k++) begin
            if (rd_req) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("rd_req_seen", ok, 1);
    endtask

    // Bridge side of one read: accept after acc_dly cycles, return nbeats
    task automatic bridge_read(input int acc_dly, input int nbeats, input bit keep);
        bit ok, oi, od;
        wait_rd_req(ok);
        if (ok) begin
            step(acc_dly);
            rd_rdy = 1; #1;
            oi = i_rd_rdy; od = d_rd_rdy;
            check("rd_accept_one_owner", oi ^ od, 1);
            @(posedge clk); #1;
            rd_rdy = 0;
            if (!keep) begin
                if (oi) i_rd_req = 0;
                if (od) d_rd_req = 0;
            end
            for (int b = 0; b < nbeats; b++) begin
                ret_valid = 1; ret_last = (b == nbeats - 1);
                @(posedge clk); #1;
            end
            ret_valid = 0; ret_last = 0;
        end
    endtask

    bit wr_acc = 0;

    // D-cache write-back plus bridge accept and delayed completion
    task automatic do_write(input logic [ADDR_W-1:0] addr, input int done_dly, output int done_cyc);
        bit ok;
        ok = 0;
        done_cyc = -1;
        d_wr_req = 1; d_wr_type = RD_TYPE_LINE; d_wr_addr = addr;
        d_wr_wstrb = 4'hf; d_wr_data = {32'hdead0003, 32'hbeef0002, 32'hcafe0001, 32'h12340000};
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (wr_req) begin ok = 1; break; end
        end
        check("wr_req_seen", ok, 1);
        if (ok) begin
            wr_rdy = 1;
            @(posedge clk); #1;
            wr_rdy = 0; d_wr_req = 0; wr_acc = 1;
            step(done_dly);
            wr_done = 1; done_cyc = cyc;
            @(posedge clk); #1;
            wr_done = 0;
        end
    endtask

    int wdone;

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        rst = 0;

        // Stray bridge responses while idle are ignored
        ret_valid = 1; ret_last = 1; wr_done = 1;
        step(1);
        ret_valid = 0; ret_last = 0; wr_done = 0;
        step(1);
        check("idle_no_beats", n_i_beats + n_d_beats, 0);

        // I-cache only, accepted two cycles after rd_req, four beats
        clear_obs();
        i_rd_type = RD_TYPE_LINE; i_rd_addr = 32'h1c000040; i_rd_req = 1;
        bridge_read(2, 4, 0);
        step(2);
        check("t1_grant_addr", g_addr(0), 32'h1c000040);
        check("t1_i_beats", n_i_beats, 4);
        check("t1_i_last", n_i_last, 1);
        check("t1_d_beats", n_d_beats, 0);

        // I and D in the same cycle: D first, I one grant-cycle after D's last beat
        clear_obs();
        d_rd_type = RD_TYPE_LINE; d_rd_addr = 32'h00002000;
        i_rd_addr = 32'h1c000080;
        d_rd_req = 1; i_rd_req = 1;
        bridge_read(1, 4, 0);
        bridge_read(1, 4, 0);
        step(2);
        check("t2_first_d", g_addr(0), 32'h00002000);
        check("t2_second_i", g_addr(1), 32'h1c000080);
        check("t2_i_after_d_last", g_cyc(1) - last_d_cyc, 2);
        check("t2_beats", {n_i_beats[7:0], n_d_beats[7:0]}, {8'd4, 8'd4});

`ifdef ARB_RR_EN
        // Continuous requests from both sides alternate D, I, D, I
        clear_obs();
        d_rd_addr = 32'h00004000; i_rd_addr = 32'h1c000400;
        d_rd_req = 1; i_rd_req = 1;
        repeat (4) bridge_read(1, 4, 1);
        d_rd_req = 0; i_rd_req = 0;
        step(3);
        check("rr_g0_d", g_addr(0), 32'h00004000);
        check("rr_g1_i", g_addr(1), 32'h1c000400);
        check("rr_g2_d", g_addr(2), 32'h00004000);
        check("rr_g3_i", g_addr(3), 32'h1c000400);
`endif

        // Read to the line of an in-flight write waits for wr_done
        clear_obs();
        wr_acc = 0;
        fork
            do_write(32'h00001230, 10, wdone);
            begin
                for (int k = 0; k < 30 && !wr_acc; k++) step(1);
                d_rd_addr = 32'h00001234; d_rd_req = 1;
                bridge_read(1, 4, 0);
            end
        join
        step(2);
        check("haz_grant_addr", g_addr(0), 32'h00001234);
        check("haz_rd_after_done", g_cyc(0) - wdone, 2);
        check("haz_d_beats", n_d_beats, 4);

        // Read to a different line proceeds while the write awaits completion
        clear_obs();
        wr_acc = 0;
        fork
            do_write(32'h00001230, 10, wdone);
            begin
                for (int k = 0; k < 30 && !wr_acc; k++) step(1);
                d_rd_addr = 32'h00001240; d_rd_req = 1;
                bridge_read(1, 4, 0);
            end
        join
        step(2);
        check("nohaz_grant_addr", g_addr(0), 32'h00001240);
        check("nohaz_rd_before_done", g_cyc(0) < wdone, 1);

        // Reset during the second return beat
        clear_obs();
        i_rd_addr = 32'h1c000100; i_rd_req = 1;
        begin
            bit ok;
            wait_rd_req(ok);
        end
        rd_rdy = 1;
        step(1);
        rd_rdy = 0; i_rd_req = 0;
        ret_valid = 1; ret_last = 0;
        step(1);
        rst = 1;
        step(1);
        check("rst_outputs_zero",
              {i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy,
               rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb}, '0);
        check("rst_wr_data_zero", wr_data, '0);
        ret_valid = 0;
        step(1);
        rst = 0;
        d_rd_addr = 32'h00003000; d_rd_req = 1;
        bridge_read(1, 4, 0);
        step(2);
        check("rst_i_beats", n_i_beats, 2);
        check("rst_i_last", n_i_last, 0);
        check("rst_new_grant", g_addr(1), 32'h00003000);
        check("rst_d_beats", n_d_beats, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
